// File: rtl/bh_pkg.sv
// -----------------------------------------------------------------------------
// bh_pkg
// Shared definitions for the tape-machine run controller:
//   - default widths for tape, program memory and instruction words
//   - width of the shared index counter and of the RUN cycle counter
//   - controller state enum
//   - instruction encodings understood by the core
// -----------------------------------------------------------------------------
package bh_pkg;

    localparam int unsigned BH_TAPE_ADDR_W = 8;
    localparam int unsigned BH_TAPE_DATA_W = 8;
    localparam int unsigned BH_PRG_ADDR_W  = 8;
    localparam int unsigned BH_INSTR_W     = 3;

    // Index counter used for LOAD/FILL/CLEAR/DUMP addressing.
    localparam int unsigned BH_IDX_W = 8;

    // RUN cycle counter width and its saturation value.
    localparam int unsigned                BH_CYCLES_W   = 16;
    localparam logic [BH_CYCLES_W-1:0]     BH_CYCLES_MAX = '1;

    // LOAD stops on this address even without a last marker, so that FILL
    // always owns at least the final program address.
    localparam logic [BH_IDX_W-1:0] BH_LOAD_END_ADDR = 8'd254;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FILL  = 3'd2,
        ST_CLEAR = 3'd3,
        ST_RUN   = 3'd4,
        ST_DUMP  = 3'd5,
        ST_DONE  = 3'd6
    } bh_state_t;

    // Instruction encodings: NOP 000, +/- 01x, >/< 10x, [/] 11x.
    typedef enum logic [2:0] {
        OP_NOP        = 3'b000,
        OP_INC        = 3'b010,
        OP_DEC        = 3'b011,
        OP_RIGHT      = 3'b100,
        OP_LEFT       = 3'b101,
        OP_LOOP_BEGIN = 3'b110,
        OP_LOOP_END   = 3'b111
    } bh_op_t;

endpackage

// File: rtl/bh_run_ctrl_seq_counter.sv
// -----------------------------------------------------------------------------
// seq_counter
// Up counter with synchronous clear, count enable and terminal-count flag.
// Clear has priority over enable. tc is high while the count is all ones,
// i.e. the final index is flagged before the counter would wrap.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset (count -> 0)
//   clr   - synchronous clear to 0
//   en    - advance by one
//   count - current count
//   tc    - count is at its maximum value
// -----------------------------------------------------------------------------
module seq_counter
    import bh_pkg::*;
#(
    parameter int unsigned W = BH_IDX_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (en) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;
    assign tc    = &count_reg;

endmodule

// File: rtl/bh_run_ctrl.sv
// -----------------------------------------------------------------------------
// bh_run_ctrl
// Session controller for a tape-machine core. One session is:
//   LOAD  - accept program stream, write program memory from address 0
//   FILL  - pad program memory with NOP from program length L up to 255
//   CLEAR - take the tape port and zero all 256 cells
//   RUN   - release the core, count cycles until PC == L or abort
//   DUMP  - stream all 256 tape cells out with valid/ready
//   DONE  - idle with results held; a new start begins another session
// Ports:
//   i_clock, i_reset_n           - clock, async active-low reset
//   i_start, i_abort             - session start, early RUN termination
//   o_busy, o_done               - session in progress / finished
//   i_prg_valid/data/last, o_prg_ready        - program load stream
//   o_prgmem_we/addr/wdata                    - program memory write port
//   o_tape_sel/we/addr/wdata, i_tape_rdata    - tape port (sel=1: controller)
//   o_core_rst_n, o_core_run, i_core_pc       - core reset / enable / PC
//   o_dump_valid/data/last, i_dump_ready      - tape dump stream
//   o_cycles                                  - saturating RUN cycle count
// -----------------------------------------------------------------------------
module bh_run_ctrl
    import bh_pkg::*;
#(
    parameter int unsigned TAPE_ADDR_W = BH_TAPE_ADDR_W,
    parameter int unsigned TAPE_DATA_W = BH_TAPE_DATA_W,
    parameter int unsigned PRG_ADDR_W  = BH_PRG_ADDR_W,
    parameter int unsigned INSTR_W     = BH_INSTR_W
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,

    input  logic                   i_start,
    input  logic                   i_abort,
    output logic                   o_busy,
    output logic                   o_done,

    input  logic                   i_prg_valid,
    input  logic [INSTR_W-1:0]     i_prg_data,
    input  logic                   i_prg_last,
    output logic                   o_prg_ready,

    output logic                   o_prgmem_we,
    output logic [PRG_ADDR_W-1:0]  o_prgmem_addr,
    output logic [INSTR_W-1:0]     o_prgmem_wdata,

    output logic                   o_tape_sel,
    output logic                   o_tape_we,
    output logic [TAPE_ADDR_W-1:0] o_tape_addr,
    output logic [TAPE_DATA_W-1:0] o_tape_wdata,
    input  logic [TAPE_DATA_W-1:0] i_tape_rdata,

    output logic                   o_core_rst_n,
    output logic                   o_core_run,
    input  logic [PRG_ADDR_W-1:0]  i_core_pc,

    output logic                   o_dump_valid,
    output logic [TAPE_DATA_W-1:0] o_dump_data,
    output logic                   o_dump_last,
    input  logic                   i_dump_ready,

    output logic [BH_CYCLES_W-1:0] o_cycles
);

    bh_state_t state_reg, state_next;

    // Shared index: LOAD/FILL walk it continuously (FILL starts where LOAD
    // stopped, i.e. at L), then it is cleared for CLEAR and again for DUMP.
    logic [BH_IDX_W-1:0]    idx;
    logic                   idx_tc;
    logic                   idx_clr;
    logic                   idx_en;

    logic [PRG_ADDR_W-1:0]  len_reg;
    logic                   len_load;

    logic [BH_CYCLES_W-1:0] cycles_reg;
    logic                   cycles_clr;
    logic                   cycles_inc;

    logic                   run_exit;

    seq_counter #(
        .W (BH_IDX_W)
    ) u_idx (
        .clk   (i_clock),
        .rst_n (i_reset_n),
        .clr   (idx_clr),
        .en    (idx_en),
        .count (idx),
        .tc    (idx_tc)
    );

    assign run_exit = (i_core_pc == len_reg) || i_abort;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            len_reg <= '0;
        end else if (len_load) begin
            len_reg <= PRG_ADDR_W'(idx) + PRG_ADDR_W'(1);
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cycles_reg <= '0;
        end else if (cycles_clr) begin
            cycles_reg <= '0;
        end else if (cycles_inc && (cycles_reg != BH_CYCLES_MAX)) begin
            cycles_reg <= cycles_reg + BH_CYCLES_W'(1);
        end
    end

    assign o_cycles = cycles_reg;

    always_comb begin
        state_next     = state_reg;
        idx_clr        = 1'b0;
        idx_en         = 1'b0;
        len_load       = 1'b0;
        cycles_clr     = 1'b0;
        cycles_inc     = 1'b0;

        o_busy         = 1'b1;
        o_done         = 1'b0;
        o_prg_ready    = 1'b0;
        o_prgmem_we    = 1'b0;
        o_prgmem_addr  = '0;
        o_prgmem_wdata = '0;
        // The controller owns the tape outside RUN; ownership is dropped while
        // reset is asserted so every output reads 0 during reset.
        o_tape_sel     = i_reset_n;
        o_tape_we      = 1'b0;
        o_tape_addr    = '0;
        o_tape_wdata   = '0;
        o_core_rst_n   = 1'b0;
        o_core_run     = 1'b0;
        o_dump_valid   = 1'b0;
        o_dump_data    = '0;
        o_dump_last    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_next = ST_LOAD;
                    idx_clr    = 1'b1;
                    cycles_clr = 1'b1;
                end
            end

            ST_LOAD: begin
                o_prg_ready   = 1'b1;
                o_prgmem_addr = PRG_ADDR_W'(idx);
                if (i_prg_valid) begin
                    o_prgmem_we    = 1'b1;
                    o_prgmem_wdata = i_prg_data;
                    idx_en         = 1'b1;
                    if (i_prg_last || (idx == BH_LOAD_END_ADDR)) begin
                        len_load   = 1'b1;
                        state_next = ST_FILL;
                    end
                end
            end

            ST_FILL: begin
                o_prgmem_we    = 1'b1;
                o_prgmem_addr  = PRG_ADDR_W'(idx);
                o_prgmem_wdata = INSTR_W'(OP_NOP);
                idx_en         = 1'b1;
                if (idx_tc) begin
                    idx_clr    = 1'b1;
                    state_next = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                o_tape_we   = 1'b1;
                o_tape_addr = TAPE_ADDR_W'(idx);
                idx_en      = 1'b1;
                if (idx_tc) begin
                    idx_clr    = 1'b1;
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                o_tape_sel   = 1'b0;
                o_core_rst_n = 1'b1;
                o_core_run   = 1'b1;
                // The exit cycle itself is not counted: o_cycles reports the
                // cycles spent before the halt/abort condition was seen.
                if (run_exit) begin
                    state_next = ST_DUMP;
                end else begin
                    cycles_inc = 1'b1;
                end
            end

            ST_DUMP: begin
                o_core_rst_n = 1'b1;
                o_tape_addr  = TAPE_ADDR_W'(idx);
                o_dump_valid = 1'b1;
                o_dump_data  = i_tape_rdata;
                o_dump_last  = idx_tc;
                if (i_dump_ready) begin
                    idx_en = 1'b1;
                    if (idx_tc) begin
                        idx_clr    = 1'b1;
                        state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                o_busy       = 1'b0;
                o_done       = 1'b1;
                o_core_rst_n = 1'b1;
                if (i_start) begin
                    state_next = ST_LOAD;
                    idx_clr    = 1'b1;
                    cycles_clr = 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bh_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bh_run_ctrl
// Drives complete load/run/dump sessions through bh_run_ctrl with a program
// memory model, a tape memory model and a tiny core model attached. Expected
// tape contents and cycle counts come from a straight-line interpretation of
// the program (or fixed values for the looping program).
// -----------------------------------------------------------------------------
module tb_bh_run_ctrl;
    import bh_pkg::*;

    logic        i_clock = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_abort = 1'b0;
    logic        o_busy, o_done;
    logic        i_prg_valid = 1'b0;
    logic [2:0]  i_prg_data = '0;
    logic        i_prg_last = 1'b0;
    logic        o_prg_ready;
    logic        o_prgmem_we;
    logic [7:0]  o_prgmem_addr;
    logic [2:0]  o_prgmem_wdata;
    logic        o_tape_sel, o_tape_we;
    logic [7:0]  o_tape_addr, o_tape_wdata, i_tape_rdata;
    logic        o_core_rst_n, o_core_run;
    logic [7:0]  i_core_pc;
    logic        o_dump_valid, o_dump_last;
    logic [7:0]  o_dump_data;
    logic        i_dump_ready = 1'b0;
    logic [15:0] o_cycles;

    always #5 i_clock = ~i_clock;

    bh_run_ctrl dut (
        .i_clock        (i_clock),
        .i_reset_n      (i_reset_n),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .i_prg_valid    (i_prg_valid),
        .i_prg_data     (i_prg_data),
        .i_prg_last     (i_prg_last),
        .o_prg_ready    (o_prg_ready),
        .o_prgmem_we    (o_prgmem_we),
        .o_prgmem_addr  (o_prgmem_addr),
        .o_prgmem_wdata (o_prgmem_wdata),
        .o_tape_sel     (o_tape_sel),
        .o_tape_we      (o_tape_we),
        .o_tape_addr    (o_tape_addr),
        .o_tape_wdata   (o_tape_wdata),
        .i_tape_rdata   (i_tape_rdata),
        .o_core_rst_n   (o_core_rst_n),
        .o_core_run     (o_core_run),
        .i_core_pc      (i_core_pc),
        .o_dump_valid   (o_dump_valid),
        .o_dump_data    (o_dump_data),
        .o_dump_last    (o_dump_last),
        .i_dump_ready   (i_dump_ready),
        .o_cycles       (o_cycles)
    );

    // ---------------- environment models ----------------
    logic [2:0] prgmem   [256];
    logic [7:0] tape_mem [256];
    logic [7:0] core_pc  = '0;
    logic [7:0] core_ptr = '0;
    logic [2:0] core_op;
    int         tape_wr_cnt = 0;
    int         prg_wr_cnt  = 0;
    bit         scramble = 1'b0;

    assign i_tape_rdata = tape_mem[o_tape_addr];
    assign i_core_pc    = core_pc;

    function automatic logic [7:0] match_back(input logic [7:0] p);
        int depth = 0;
        for (int j = int'(p) - 1; j >= 0; j--) begin
            if (prgmem[j] == 3'b111) depth++;
            else if (prgmem[j] == 3'b110) begin
                if (depth == 0) return 8'(j);
                depth--;
            end
        end
        return 8'd0;
    endfunction

    function automatic logic [7:0] match_fwd(input logic [7:0] p);
        int depth = 0;
        for (int j = int'(p) + 1; j < 256; j++) begin
            if (prgmem[j] == 3'b110) depth++;
            else if (prgmem[j] == 3'b111) begin
                if (depth == 0) return 8'(j);
                depth--;
            end
        end
        return 8'd255;
    endfunction

    always @(posedge i_clock) begin
        if (scramble) begin
            for (int i = 0; i < 256; i++) prgmem[i] <= 3'($urandom);
        end else if (o_prgmem_we) begin
            prgmem[o_prgmem_addr] <= o_prgmem_wdata;
            prg_wr_cnt <= prg_wr_cnt + 1;
        end
    end

    always @(posedge i_clock) begin
        if (scramble) begin
            for (int i = 0; i < 256; i++) tape_mem[i] <= 8'($urandom);
        end else if (o_tape_sel && o_tape_we) begin
            tape_mem[o_tape_addr] <= o_tape_wdata;
            tape_wr_cnt <= tape_wr_cnt + 1;
        end else if (!o_tape_sel && o_core_rst_n && o_core_run) begin
            core_op = prgmem[core_pc];
            case (core_op)
                3'b010: begin tape_mem[core_ptr] <= tape_mem[core_ptr] + 8'd1; core_pc <= core_pc + 8'd1; end
                3'b011: begin tape_mem[core_ptr] <= tape_mem[core_ptr] - 8'd1; core_pc <= core_pc + 8'd1; end
                3'b100: begin core_ptr <= core_ptr + 8'd1; core_pc <= core_pc + 8'd1; end
                3'b101: begin core_ptr <= core_ptr - 8'd1; core_pc <= core_pc + 8'd1; end
                3'b110: core_pc <= (tape_mem[core_ptr] == 8'd0) ? match_fwd(core_pc) + 8'd1 : core_pc + 8'd1;
                3'b111: core_pc <= (tape_mem[core_ptr] != 8'd0) ? match_back(core_pc) + 8'd1 : core_pc + 8'd1;
                default: core_pc <= core_pc + 8'd1;
            endcase
        end
        if (!o_core_rst_n) begin
            core_pc  <= '0;
            core_ptr <= '0;
        end
    end

    // ---------------- reference model & checking ----------------
    int          vectors = 0;
    int          miscompares = 0;
    logic [2:0]  prog     [256];
    logic [7:0]  exp_tape [256];
    int          exp_cycles;
    logic [2:0]  ops_tab  [5] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Straight-line program: every instruction takes one cycle, tape effect
    // is plain modulo-256 arithmetic on the cell under the pointer.
    task automatic ref_straight(input int n);
        int ptr = 0;
        for (int i = 0; i < 256; i++) exp_tape[i] = 8'd0;
        for (int i = 0; i < n; i++) begin
            case (prog[i])
                3'b010: exp_tape[ptr] = exp_tape[ptr] + 8'd1;
                3'b011: exp_tape[ptr] = exp_tape[ptr] - 8'd1;
                3'b100: ptr = (ptr + 1) % 256;
                3'b101: ptr = (ptr + 255) % 256;
                default: ;
            endcase
        end
        exp_cycles = n;
    endtask

    task automatic random_prog(input int n);
        for (int i = 0; i < n; i++) prog[i] = ops_tab[$urandom_range(0, 4)];
    endtask

    task automatic do_scramble();
        @(negedge i_clock);
        scramble = 1'b1;
        @(negedge i_clock);
        scramble = 1'b0;
    endtask

    task automatic start_pulse();
        @(negedge i_clock);
        i_start = 1'b1;
        @(negedge i_clock);
        i_start = 1'b0;
        chk("start_prg_ready", o_prg_ready, 1);
        chk("start_busy", o_busy, 1);
        chk("start_cycles_cleared", o_cycles, 0);
    endtask

    task automatic load_prog(input int n, input bit use_last);
        int not_ready = 0;
        for (int i = 0; i < n; i++) begin
            i_prg_valid = 1'b1;
            i_prg_data  = prog[i];
            i_prg_last  = use_last && (i == n - 1);
            #1;
            if (!o_prg_ready) not_ready++;
            @(negedge i_clock);
        end
        i_prg_valid = 1'b0;
        i_prg_last  = 1'b0;
        chk("load_ready", not_ready, 0);
    endtask

    task automatic run_session(input int n, input bit use_last, input int abort_after, input bit poke);
        int tw0, pw0, k, bad, beat, cyc;
        bit prev_stall;
        logic [7:0] prev_data;
        tw0 = tape_wr_cnt;
        pw0 = prg_wr_cnt;
        load_prog(n, use_last);

        k = 0;
        while (!o_core_run && k < 1000) begin @(negedge i_clock); k++; end
        chk("run_entry", o_core_run, 1);
        chk("run_tape_sel", o_tape_sel, 0);
        chk("run_core_rst_n", o_core_rst_n, 1);
        bad = 0;
        for (int a = 0; a < 256; a++)
            if (prgmem[a] !== ((a < n) ? prog[a] : 3'b000)) bad++;
        chk("prgmem_image", bad, 0);
        chk("prgmem_writes", prg_wr_cnt - pw0, 256);
        chk("tape_clear_writes", tape_wr_cnt - tw0, 256);

        if (abort_after > 0) begin
            repeat (abort_after) @(negedge i_clock);
            chk("abort_pre_run", o_core_run, 1);
            chk("abort_pre_cycles", o_cycles, abort_after);
            i_abort = 1'b1;
            @(negedge i_clock);
            i_abort = 1'b0;
            chk("abort_run_low", o_core_run, 0);
            chk("abort_dump_valid", o_dump_valid, 1);
        end else begin
            if (poke) begin
                i_start = 1'b1;
                @(negedge i_clock);
                i_start = 1'b0;
                chk("start_in_run_ready", o_prg_ready, 0);
                chk("start_in_run_run", o_core_run, 1);
            end
            k = 0;
            while (!o_dump_valid && k < 2000) begin @(negedge i_clock); k++; end
            chk("dump_entry", o_dump_valid, 1);
            chk("halt_run_low", o_core_run, 0);
        end
        chk("cycles", o_cycles, exp_cycles);

        beat = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
        while (beat < 256 && cyc < 5000) begin
            i_dump_ready = 1'($urandom_range(0, 1));
            #1;
            if (prev_stall) chk("dump_stable", o_dump_data, prev_data);
            if (o_dump_valid && i_dump_ready) begin
                chk($sformatf("dump_data[%0d]", beat), o_dump_data, exp_tape[beat]);
                chk($sformatf("dump_last[%0d]", beat), o_dump_last, (beat == 255));
                beat++;
            end
            prev_stall = o_dump_valid && !i_dump_ready;
            prev_data  = o_dump_data;
            cyc++;
            @(negedge i_clock);
        end
        i_dump_ready = 1'b0;
        chk("dump_beats", beat, 256);
        chk("done_flag", o_done, 1);
        chk("done_busy", o_busy, 0);
        chk("done_valid", o_dump_valid, 0);
        $display("session L=%0d abort=%0d cycles=%0d beats=%0d", n, abort_after, o_cycles, beat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, tw0;
        // Reset state
        #2;
        chk("reset_ctrl_outputs", {o_busy, o_done, o_prg_ready, o_prgmem_we, o_tape_sel,
                                   o_tape_we, o_core_rst_n, o_core_run, o_dump_valid, o_dump_last}, 0);
        chk("reset_addrs", {o_prgmem_addr, o_tape_addr, o_dump_data}, 0);
        chk("reset_cycles", o_cycles, 0);
        repeat (2) @(negedge i_clock);
        i_reset_n = 1'b1;
        #1;
        chk("idle_busy", o_busy, 0);
        chk("idle_tape_sel", o_tape_sel, 1);
        chk("idle_core_rst_n", o_core_rst_n, 0);

        // "+++" with last marker on beat 3
        prog[0] = 3'b010; prog[1] = 3'b010; prog[2] = 3'b010;
        ref_straight(3);
        do_scramble();
        start_pulse();
        run_session(3, 1'b1, 0, 1'b0);

        // 255 beats without last, start pulsed during RUN
        random_prog(255);
        ref_straight(255);
        do_scramble();
        start_pulse();
        run_session(255, 1'b0, 0, 1'b1);

        // "+[]" loops forever; abort after 100 RUN cycles
        prog[0] = 3'b010; prog[1] = 3'b110; prog[2] = 3'b111;
        for (int i = 0; i < 256; i++) exp_tape[i] = 8'd0;
        exp_tape[0] = 8'd1;
        exp_cycles  = 100;
        do_scramble();
        start_pulse();
        run_session(3, 1'b1, 100, 1'b0);

        // Reset in the middle of CLEAR
        prog[0] = 3'b010; prog[1] = 3'b010; prog[2] = 3'b010;
        do_scramble();
        start_pulse();
        tw0 = tape_wr_cnt;
        load_prog(3, 1'b1);
        k = 0;
        while (!(o_tape_we && o_tape_addr == 8'd37) && k < 1000) begin @(negedge i_clock); k++; end
        chk("clear_idx37_reached", {o_tape_we, o_tape_addr}, {1'b1, 8'd37});
        i_reset_n = 1'b0;
        #1;
        chk("midclear_tape_we", o_tape_we, 0);
        chk("midclear_core_rst_n", o_core_rst_n, 0);
        chk("midclear_busy", o_busy, 0);
        chk("midclear_tape_sel", o_tape_sel, 0);
        repeat (3) @(negedge i_clock);
        chk("midclear_writes", tape_wr_cnt - tw0, 37);
        i_reset_n = 1'b1;
        #1;
        chk("post_reset_busy", o_busy, 0);
        chk("post_reset_cycles", o_cycles, 0);
        $display("reset at CLEAR index 37 observed");

        // Full sessions after reset, random lengths
        for (int s = 0; s < 2; s++) begin
            int n;
            n = $urandom_range(1, 200);
            random_prog(n);
            ref_straight(n);
            do_scramble();
            start_pulse();
            run_session(n, 1'b1, 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bh_run_ctrl.md
BH_RUN_CTRL -- requirements
Module: bh_run_ctrl

Interface
REQ-001 The block SHALL have parameter TAPE_ADDR_W, default 8, tape address width (256 cells).
REQ-002 The block SHALL have parameter TAPE_DATA_W, default 8, tape cell width.
REQ-003 The block SHALL have parameter PRG_ADDR_W, default 8, program memory address width.
REQ-004 The block SHALL have parameter INSTR_W, default 3, instruction width.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: i_clock (in, 1, rising-edge clock) and i_reset_n (in, 1, async active-low reset).
REQ-006 The block SHALL have these control ports: i_start (in, 1, begins a load/run/dump session); i_abort (in, 1, ends RUN early); o_busy (out, 1, high outside IDLE/DONE); o_done (out, 1, high in DONE).
REQ-007 The block SHALL have these program load stream ports: i_prg_valid (in, 1); i_prg_data (in, INSTR_W); i_prg_last (in, 1); o_prg_ready (out, 1).
REQ-008 The block SHALL have these program memory write ports: o_prgmem_we (out, 1); o_prgmem_addr (out, PRG_ADDR_W); o_prgmem_wdata (out, INSTR_W).
REQ-009 The block SHALL have these tape port mux ports: o_tape_sel (out, 1, 1 = controller owns tape); o_tape_we (out, 1); o_tape_addr (out, TAPE_ADDR_W); o_tape_wdata (out, TAPE_DATA_W); i_tape_rdata (in, TAPE_DATA_W, combinational read).
REQ-010 The block SHALL have these core control ports: o_core_rst_n (out, 1); o_core_run (out, 1, core clock enable); i_core_pc (in, PRG_ADDR_W).
REQ-011 The block SHALL have these dump stream ports: o_dump_valid (out, 1); o_dump_data (out, TAPE_DATA_W); o_dump_last (out, 1); i_dump_ready (in, 1).
REQ-012 The block SHALL have o_cycles (out, 16, RUN cycle count).

Function
REQ-013 The block SHALL implement FSM states IDLE, LOAD, FILL, CLEAR, RUN, DUMP, DONE.
REQ-014 IDLE SHALL go to LOAD on i_start; i_start SHALL be ignored in all other states except DONE, where it also goes to LOAD and clears o_cycles.
REQ-015 In LOAD, o_prg_ready SHALL be 1, and each beat (valid && ready) SHALL write i_prg_data to address load_idx (starting at 0) in the same cycle and then increment load_idx.
REQ-016 The beat carrying i_prg_last, or the beat at address 254, SHALL end LOAD; the program length L SHALL be load_idx+1 (range 1..255); LOAD SHALL then go to FILL.
REQ-017 FILL SHALL write NOP (000) one address per cycle, from L through 255 inclusive, then go to CLEAR.
REQ-018 CLEAR SHALL hold o_tape_sel=1 and write 0 to tape addresses 0..255, one per cycle (256 cycles), then go to RUN.
REQ-019 o_core_rst_n SHALL be 0 in IDLE, LOAD, FILL and CLEAR, and 1 otherwise; o_tape_sel SHALL be 0 only in RUN.
REQ-020 In RUN, o_core_run SHALL be 1 and o_cycles SHALL increment each cycle, saturating at 0xFFFF.
REQ-021 RUN SHALL go to DUMP on the first rising edge where i_core_pc == L or i_abort == 1, and o_core_run SHALL be 0 from the next cycle.
REQ-022 In DUMP, o_tape_addr SHALL equal dump_idx (from 0), o_dump_data SHALL equal i_tape_rdata, o_dump_valid SHALL be 1, and o_dump_last SHALL be (dump_idx == 255).
REQ-023 In DUMP, dump_idx SHALL advance only on valid && ready, data SHALL stay stable while stalled, and the last handshake SHALL go to DONE.
REQ-024 Index counters SHALL be 8-bit; the end condition SHALL be detected at 255 before wrap, so no address is visited twice.

Reset
REQ-025 Asserting i_reset_n low in any state SHALL immediately force IDLE, and all outputs SHALL go to 0 except o_core_rst_n, which SHALL go to 0 (core held in reset).
REQ-026 On reset, o_cycles, L, load_idx and dump_idx SHALL all be 0; a reset mid-LOAD, mid-CLEAR or mid-DUMP SHALL abandon the session with no further writes or beats.

Structure
REQ-027 Package bh_pkg SHALL hold the width constants, the state enum and the instruction encodings (NOP 000, +/- 01x, >/< 10x, [/] 11x).
REQ-028 A single sub-module, seq_counter (8-bit up counter with clear, enable and terminal-count flag), SHALL be shared by the LOAD, FILL, CLEAR and DUMP indices.

Verification
REQ-029 Load "+++" (3 beats, last on beat 3), then RUN: expect L=3, NOP writes to prgmem 3..255, 256 tape clears, halt when PC=3, and dump cell0=3, cells1..255=0, o_cycles=3.
REQ-030 Load 255 beats with no i_prg_last: expect LOAD to end at address 254, FILL to write only address 255, and RUN to halt at PC=255.
REQ-031 Use a program that loops forever, assert i_abort after 100 RUN cycles: expect DUMP entered, o_cycles=100, and o_core_run low on the next cycle.
REQ-032 In DUMP, toggle i_dump_ready at random: expect 256 beats, data stable while stalled, o_dump_last only on beat 256, then DONE.
REQ-033 Assert i_reset_n low at CLEAR index 37: expect o_tape_we=0 immediately, IDLE, o_core_rst_n=0; after release, a new i_start runs a full session correctly.
REQ-034 Pulse i_start during RUN (ignored); in DONE, pulse i_start: expect LOAD, o_cycles=0, o_prg_ready=1.
